// File: rtl/irq_trap_ctrl.sv
// ============================================================================
// irq_trap_ctrl
// ----------------------------------------------------------------------------
// Machine-mode interrupt entry / MRET exit controller for a single-issue core.
// When an enabled interrupt is pending and a valid instruction sits in the
// commit stage, that instruction is turned into the trap point. Its PC goes
// to mepc, the cause goes to mcause, MIE is saved, and the pipeline is
// redirected to the trap vector. A committing MRET redirects to mepc and
// restores MIE.
//
// Sequence:  IDLE -> TRAP (CSR writes) -> TRAP_REDIR (PC redirect) -> IDLE
//            IDLE -> MRET (PC redirect + MIE restore)               -> IDLE
//
// Configuration macro:
//   TRAP_VECTORED_EN  defined   : mtvec mode 2'b01 selects vectored entry
//                                 (base + 4*cause_code); other modes use base.
//                     undefined : direct entry at base; mtvec_in[1:0] ignored.
//
// Parameters:
//   XLEN          data / PC width (>= 5)
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   ext_irq       external interrupt level (asynchronous, synchronized here)
//   timer_irq     timer interrupt level (synchronous to clk)
//   instr_valid   valid instruction in the commit stage
//   is_mret       commit-stage instruction is MRET
//   pc_in         PC of the commit-stage instruction
//   mtvec_in      current mtvec CSR value
//   mepc_in       current mepc CSR value
//   mstatus_mie   global machine interrupt enable
//   mie_meie      external interrupt enable
//   mie_mtie      timer interrupt enable
//   mepc_we       mepc write strobe
//   mcause_we     mcause write strobe
//   mepc_out      mepc write data
//   mcause_out    mcause write data
//   mstatus_trap  MIE -> MPIE save, MIE clear
//   mstatus_mret  MPIE -> MIE restore
//   flush         kill fetch and commit-stage instructions
//   stall         hold PC and pipeline registers
//   redirect_en   load the PC with redirect_pc
//   redirect_pc   redirect target
// ============================================================================
module irq_trap_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            instr_valid,
    input  logic            is_mret,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    output logic            mepc_we,
    output logic            mcause_we,
    output logic [XLEN-1:0] mepc_out,
    output logic [XLEN-1:0] mcause_out,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic            flush,
    output logic            stall,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc
);

    // Interrupt bit of mcause and the machine-level cause codes.
    localparam logic [XLEN-1:0] INT_FLAG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [3:0]      CODE_EXT = 4'd11;
    localparam logic [3:0]      CODE_TMR = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        TRAP_REDIR,
        MRET
    } state_t;

    state_t state;
    state_t state_next;

    logic            sync_meta;
    logic            ext_sync;
    logic            irq_ext_req;
    logic            irq_tmr_req;
    logic            irq_take;
    logic            trap_start;

    logic [XLEN-1:0] trap_pc;
    logic            trap_ext;
    logic [3:0]      trap_code;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_target;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous external interrupt.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            ext_sync  <= 1'b0;
        end else begin
            sync_meta <= ext_irq;
            ext_sync  <= sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Request qualification. Only meaningful in IDLE; other states ignore it.
    // ------------------------------------------------------------------------
    assign irq_ext_req = ext_sync  & mie_meie;
    assign irq_tmr_req = timer_irq & mie_mtie;
    assign irq_take    = instr_valid & mstatus_mie & (irq_ext_req | irq_tmr_req);
    assign trap_start  = (state == IDLE) & irq_take;

    // ------------------------------------------------------------------------
    // Trap PC and source, captured on the IDLE->TRAP edge and held until the
    // next trap so TRAP and TRAP_REDIR see stable values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pc  <= '0;
            trap_ext <= 1'b0;
        end else if (trap_start) begin
            trap_pc  <= pc_in;
            // External wins when both sources are requesting.
            trap_ext <= irq_ext_req;
        end
    end

    assign trap_code  = trap_ext ? CODE_EXT : CODE_TMR;
    assign mtvec_base = {mtvec_in[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = mtvec_base;
        if (mtvec_in[1:0] == 2'b01) begin
            trap_target = mtvec_base + XLEN'({trap_code, 2'b00});
        end
    end
`else
    // Mode bits have no effect in direct-only builds.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_in[1:0];
    assign trap_target       = mtvec_base;
`endif

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and Moore output decode. IDLE drives every output to zero,
    // so an asynchronous reset silences the outputs at once, including a
    // CSR write that was in progress.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        mepc_we      = 1'b0;
        mcause_we    = 1'b0;
        mepc_out     = '0;
        mcause_out   = '0;
        mstatus_trap = 1'b0;
        mstatus_mret = 1'b0;
        flush        = 1'b0;
        stall        = 1'b0;
        redirect_en  = 1'b0;
        redirect_pc  = '0;

        unique case (state)
            IDLE: begin
                // An interrupt takes priority over a simultaneous MRET.
                if (irq_take) begin
                    state_next = TRAP;
                end else if (instr_valid && is_mret) begin
                    state_next = MRET;
                end
            end

            TRAP: begin
                mepc_we      = 1'b1;
                mepc_out     = trap_pc;
                mcause_we    = 1'b1;
                mcause_out   = INT_FLAG | XLEN'(trap_code);
                mstatus_trap = 1'b1;
                flush        = 1'b1;
                stall        = 1'b1;
                state_next   = TRAP_REDIR;
            end

            TRAP_REDIR: begin
                redirect_en = 1'b1;
                redirect_pc = trap_target;
                flush       = 1'b1;
                state_next  = IDLE;
            end

            MRET: begin
                redirect_en  = 1'b1;
                redirect_pc  = mepc_in;
                mstatus_mret = 1'b1;
                flush        = 1'b1;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// ============================================================================
// tb_irq_trap_ctrl
// Self-checking bench for irq_trap_ctrl (XLEN = 32). Inputs are driven and
// outputs compared on the falling clock edge. Honors TRAP_VECTORED_EN the
// same way the design does when it is defined on the command line.
// ============================================================================
`timescale 1ns/1ps
module tb_irq_trap_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ext_irq;
    logic            timer_irq;
    logic            instr_valid;
    logic            is_mret;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] mtvec_in;
    logic [XLEN-1:0] mepc_in;
    logic            mstatus_mie;
    logic            mie_meie;
    logic            mie_mtie;
    logic            mepc_we;
    logic            mcause_we;
    logic [XLEN-1:0] mepc_out;
    logic [XLEN-1:0] mcause_out;
    logic            mstatus_trap;
    logic            mstatus_mret;
    logic            flush;
    logic            stall;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    irq_trap_ctrl #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .instr_valid  (instr_valid),
        .is_mret      (is_mret),
        .pc_in        (pc_in),
        .mtvec_in     (mtvec_in),
        .mepc_in      (mepc_in),
        .mstatus_mie  (mstatus_mie),
        .mie_meie     (mie_meie),
        .mie_mtie     (mie_mtie),
        .mepc_we      (mepc_we),
        .mcause_we    (mcause_we),
        .mepc_out     (mepc_out),
        .mcause_out   (mcause_out),
        .mstatus_trap (mstatus_trap),
        .mstatus_mret (mstatus_mret),
        .flush        (flush),
        .stall        (stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc)
    );

    // ------------------------------------------------------------------------
    // Output bundle and expected-value builders
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        mepc_we;
        logic        mcause_we;
        logic [31:0] mepc_out;
        logic [31:0] mcause_out;
        logic        mstatus_trap;
        logic        mstatus_mret;
        logic        flush;
        logic        stall;
        logic        redirect_en;
        logic [31:0] redirect_pc;
    } outs_t;

    localparam logic [31:0] C_EXT = 32'h8000000B;
    localparam logic [31:0] C_TMR = 32'h80000007;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] V_TMR_201 = 32'h0000021C;
    localparam logic [31:0] V_EXT_201 = 32'h0000022C;
`else
    localparam logic [31:0] V_TMR_201 = 32'h00000200;
    localparam logic [31:0] V_EXT_201 = 32'h00000200;
`endif

    int total = 0;
    int bad   = 0;

    function automatic outs_t o_idle();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t o_trap(input logic [31:0] pc, input logic [31:0] cause);
        outs_t o = '0;
        o.mepc_we      = 1'b1;
        o.mcause_we    = 1'b1;
        o.mepc_out     = pc;
        o.mcause_out   = cause;
        o.mstatus_trap = 1'b1;
        o.flush        = 1'b1;
        o.stall        = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_redir(input logic [31:0] target);
        outs_t o = '0;
        o.redirect_en = 1'b1;
        o.redirect_pc = target;
        o.flush       = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_mret(input logic [31:0] target);
        outs_t o = '0;
        o.redirect_en  = 1'b1;
        o.redirect_pc  = target;
        o.mstatus_mret = 1'b1;
        o.flush        = 1'b1;
        return o;
    endfunction

    // Trap entry address from the architectural rule.
    function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic is_ext);
        logic [31:0] base;
        base = mtvec & ~32'd3;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01) begin
            return base + 32'd4 * (is_ext ? 32'd11 : 32'd7);
        end
`endif
        return base;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = '{mepc_we, mcause_we, mepc_out, mcause_out, mstatus_trap,
                mstatus_mret, flush, stall, redirect_en, redirect_pc};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got we=%b/%b mepc=%h mcause=%h trap=%b mret=%b flush=%b stall=%b redir=%b pc=%h ; want we=%b/%b mepc=%h mcause=%h trap=%b mret=%b flush=%b stall=%b redir=%b pc=%h",
                     name, got.mepc_we, got.mcause_we, got.mepc_out, got.mcause_out,
                     got.mstatus_trap, got.mstatus_mret, got.flush, got.stall,
                     got.redirect_en, got.redirect_pc,
                     exp.mepc_we, exp.mcause_we, exp.mepc_out, exp.mcause_out,
                     exp.mstatus_trap, exp.mstatus_mret, exp.flush, exp.stall,
                     exp.redirect_en, exp.redirect_pc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        ext;
        logic        tmr;
        logic        mret;
        logic        mie;
        logic        meie;
        logic        mtie;
        logic [31:0] pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          kind;     // 0 nothing, 1 trap, 2 mret
        logic [31:0] cause;
        logic [31:0] target;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        instr_valid = 1'b0;
        is_mret     = v.mret;
        ext_irq     = v.ext;
        timer_irq   = v.tmr;
        mstatus_mie = v.mie;
        mie_meie    = v.meie;
        mie_mtie    = v.mtie;
        pc_in       = v.pc;
        mtvec_in    = v.mtvec;
        mepc_in     = v.mepc;
        repeat (3) @(negedge clk);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        case (v.kind)
            1:       check($sformatf("vec%0d_c1", idx), o_trap(v.pc, v.cause));
            2:       check($sformatf("vec%0d_c1", idx), o_mret(v.mepc));
            default: check($sformatf("vec%0d_c1", idx), o_idle());
        endcase
        @(negedge clk);
        if (v.kind == 1) check($sformatf("vec%0d_c2", idx), o_redir(v.target));
        else             check($sformatf("vec%0d_c2", idx), o_idle());
        ext_irq   = 1'b0;
        timer_irq = 1'b0;
        is_mret   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Reference model for random stimulus: a queue of scheduled output
    // cycles. While the queue holds entries the controller is busy.
    // ------------------------------------------------------------------------
    typedef struct {
        int          kind;     // 1 trap write, 2 trap redirect, 3 mret
        logic [31:0] pc;
        logic        is_ext;
    } sched_t;

    sched_t exp_q[$];
    logic   ext_hist[$];

    function automatic outs_t model_now();
        if (exp_q.size() == 0) return o_idle();
        case (exp_q[0].kind)
            1:       return o_trap(exp_q[0].pc, exp_q[0].is_ext ? C_EXT : C_TMR);
            2:       return o_redir(trap_vector(mtvec_in, exp_q[0].is_ext));
            default: return o_mret(mepc_in);
        endcase
    endfunction

    task automatic model_step();
        logic   sync_v;
        logic   want_ext;
        logic   want_tmr;
        sched_t s;
        if (rst) begin
            exp_q.delete();
            ext_hist.delete();
            return;
        end
        ext_hist.push_back(ext_irq);
        if (ext_hist.size() > 3) void'(ext_hist.pop_front());
        // Level seen by the controller lags the pin by two samples.
        sync_v = (ext_hist.size() == 3) ? ext_hist[0] : 1'b0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else begin
            want_ext = sync_v & mie_meie;
            want_tmr = timer_irq & mie_mtie;
            if (instr_valid && mstatus_mie && (want_ext || want_tmr)) begin
                s.pc = pc_in; s.is_ext = want_ext;
                s.kind = 1; exp_q.push_back(s);
                s.kind = 2; exp_q.push_back(s);
            end else if (instr_valid && is_mret) begin
                s.pc = '0; s.is_ext = 1'b0; s.kind = 3;
                exp_q.push_back(s);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h0,   1, C_EXT, 32'h200};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'h0,   1, C_EXT, 32'h200};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h208, 32'h201, 32'h0,   1, C_TMR, V_TMR_201};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h010, 32'h200, 32'h344, 2, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h050, 32'h200, 32'h344, 1, C_EXT, 32'h200};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h060, 32'h200, 32'h0,   0, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h070, 32'h200, 32'h0,   0, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h080, 32'h200, 32'h0,   0, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h090, 32'h203, 32'h0,   1, C_TMR, 32'h200};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0A0, 32'h201, 32'h0,   1, C_EXT, V_EXT_201};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0B0, 32'h200, 32'h1000,2, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFF00, 32'h0, 1, C_EXT, 32'hFFFFFF00};

        rst = 1'b1; ext_irq = 1'b0; timer_irq = 1'b0; instr_valid = 1'b0; is_mret = 1'b0;
        pc_in = '0; mtvec_in = '0; mepc_in = '0;
        mstatus_mie = 1'b0; mie_meie = 1'b0; mie_mtie = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset", o_idle());
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Synchronizer latency and re-evaluation of a still-pending level.
        mstatus_mie = 1'b1; mie_meie = 1'b1; mie_mtie = 1'b1;
        pc_in = 32'h400; mtvec_in = 32'h300; mepc_in = 32'h0;
        ext_irq = 1'b1; instr_valid = 1'b1;
        @(negedge clk); check("sync_c1", o_idle());
        @(negedge clk); check("sync_c2", o_idle());
        @(negedge clk); check("sync_trap", o_trap(32'h400, C_EXT));
        pc_in = 32'h404;   // must not disturb the captured PC
        @(negedge clk); check("sync_redir", o_redir(32'h300));
        @(negedge clk); check("reidle", o_idle());
        @(negedge clk); check("retake_trap", o_trap(32'h404, C_EXT));
        @(negedge clk); check("retake_redir", o_redir(32'h300));
        ext_irq = 1'b0; instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a trap.
        pc_in = 32'h600; ext_irq = 1'b1;
        repeat (3) @(negedge clk);
        instr_valid = 1'b1;
        @(negedge clk); check("pre_rst_trap", o_trap(32'h600, C_EXT));
        #1 rst = 1'b1;
        #1 check("rst_mid_trap", o_idle());
        ext_irq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_%0d", i), o_idle());
        end
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized run against the reference model.
        exp_q.delete();
        ext_hist.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check($sformatf("rand_%0d", c), model_now());
            rst         = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) ext_irq   = ~ext_irq;
            if ($urandom_range(0, 9) == 0) timer_irq = ~timer_irq;
            instr_valid = ($urandom_range(0, 9) < 7);
            is_mret     = ($urandom_range(0, 4) == 0);
            mstatus_mie = ($urandom_range(0, 5) != 0);
            mie_meie    = ($urandom_range(0, 5) != 0);
            mie_mtie    = ($urandom_range(0, 5) != 0);
            pc_in       = $urandom() & ~32'd3;
            mtvec_in    = $urandom();
            if ($urandom_range(0, 1) == 0) mtvec_in[1:0] = 2'b01;
            mepc_in     = $urandom();
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_trap_ctrl.md
IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

Interface
REQ-001 Parameter XLEN, default 32: data and PC width.
REQ-002 clk  in  1: single clock, rising edge.
REQ-003 rst  in  1: asynchronous, active-high reset.
REQ-004 ext_irq  in  1: external interrupt, level, asynchronous to clk.
REQ-005 timer_irq  in  1: timer interrupt, level, synchronous to clk.
REQ-006 instr_valid  in  1: a valid instruction occupies the commit stage this cycle.
REQ-007 is_mret  in  1: the commit-stage instruction is MRET.
REQ-008 pc_in  in  XLEN: PC of the commit-stage instruction.
REQ-009 mtvec_in, mepc_in  in  XLEN each: current CSR values.
REQ-010 mstatus_mie, mie_meie, mie_mtie  in  1 each: global and per-source enables.
REQ-011 mepc_we, mcause_we  out  1 each: CSR write strobes.
REQ-012 mepc_out, mcause_out  out  XLEN each: CSR write data.
REQ-013 mstatus_trap, mstatus_mret  out  1 each: MIE->MPIE save/clear, MPIE->MIE restore.
REQ-014 flush  out  1: kill the fetch and commit-stage instructions.
REQ-015 stall  out  1: hold the PC and pipeline registers.
REQ-016 redirect_en  out  1; redirect_pc  out  XLEN: load the PC with redirect_pc.

Function
REQ-017 ext_irq shall pass through a 2-flop synchronizer (ext_sync); timer_irq is used directly.
REQ-018 FSM states: IDLE, TRAP, TRAP_REDIR, MRET.
REQ-019 irq_take = instr_valid & mstatus_mie & ((ext_sync & mie_meie) | (timer_irq & mie_mtie)), evaluated only in IDLE.
REQ-020 IDLE->TRAP on irq_take; source is latched: external over timer when both are set.
REQ-021 IDLE->MRET on instr_valid & is_mret & !irq_take; the interrupt wins any simultaneous MRET.
REQ-022 TRAP (1 cycle) asserts:
- mepc_we=1, mepc_out=latched pc_in
- mcause_we=1, mcause_out=0x8000000B (external) or 0x80000007 (timer)
- mstatus_trap=1, flush=1, stall=1
REQ-023 TRAP->TRAP_REDIR unconditionally.
REQ-024 TRAP_REDIR (1 cycle) asserts redirect_en=1, flush=1, stall=0, redirect_pc=trap vector; the state then returns to IDLE.
REQ-025 MRET (1 cycle) asserts redirect_en=1, redirect_pc=mepc_in, mstatus_mret=1, flush=1; the state then returns to IDLE.
REQ-026 New requests are ignored outside IDLE; a level interrupt still pending is re-evaluated on return to IDLE.
REQ-027 pc_in and the cause shall be registered on the IDLE->TRAP edge and held stable through TRAP.
REQ-028 All outputs not listed for a state shall be 0; outputs are Moore-decoded from state and registered data.
REQ-029 Trap latency: 1 cycle from the irq_take sample edge to mepc_we, 2 cycles to redirect_en.

Reset
REQ-030 rst shall immediately force state=IDLE, clear the synchronizer flops, and clear the latched pc and cause.
REQ-031 Under rst all outputs shall be 0, including mid-TRAP; no partial CSR write shall be issued after rst is released.

Configuration
REQ-032 Macro TRAP_VECTORED_EN controls the trap vector:
- Defined, mtvec_in[1:0]==2'b01: redirect_pc = {mtvec_in[XLEN-1:2],2'b00} + 4*cause_code (11 external, 7 timer).
- Defined, any other mode: redirect_pc = {mtvec_in[XLEN-1:2],2'b00}.
REQ-033 Macro TRAP_VECTORED_EN undefined: redirect_pc = {mtvec_in[XLEN-1:2],2'b00} always; mtvec_in[1:0] is ignored.

Verification
REQ-034 mie=1, meie=1, ext_irq=1, pc_in=0x100, mtvec=0x200 -> after sync, mepc_out=0x100, mcause=0x8000000B, next cycle redirect_pc=0x200.
REQ-035 ext_irq and timer_irq both high, both enabled -> mcause=0x8000000B; after return to IDLE with MIE re-enabled, timer trap mcause=0x80000007.
REQ-036 is_mret=1, instr_valid=1, mepc_in=0x344 -> one cycle redirect_en=1, redirect_pc=0x344, mstatus_mret=1.
REQ-037 Interrupt and is_mret in the same cycle, pc_in=0x50 -> trap taken, mepc_out=0x50, no mstatus_mret.
REQ-038 TRAP_VECTORED_EN defined, mtvec=0x201, timer trap -> redirect_pc=0x21C; macro undefined -> 0x200.
REQ-039 rst asserted during TRAP -> outputs 0 at once; after release, state IDLE and no mepc_we without a new irq_take.
